// File: rtl/frame_sequencer_if.sv
// Bit-stream bundle between the frame sequencer, its upstream bit source and the modulator.
// master = sequencer side; slave = the environment that sources payload bits and sinks the frame.
interface frame_sequencer_if;
  logic s_tvalid;
  logic s_tdata;
  logic s_tready;
  logic m_tvalid;
  logic m_tdata;
  logic m_tready;
  logic m_tlast;

  modport master (
    input  s_tvalid, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast
  );

  modport slave (
    output s_tvalid, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast
  );
endinterface

// File: rtl/frame_sequencer.sv
// Framer: preamble, pass-through payload, idle gap, repeated per run; first preamble bit valid 1 cycle after start.
// Preamble stalls on m_tready; payload is combinational so s_tready follows m_tready and nothing is buffered.
module frame_sequencer #(
  parameter int unsigned PRE_LEN = 16,
  parameter logic [31:0] PRE_PAT = 32'h0000_A5A5,
  parameter int unsigned PAY_LEN = 64,
  parameter int unsigned GAP_LEN = 8,
  parameter int unsigned NFRAMES = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               stop,
  frame_sequencer_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic [15:0]        frame_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_PAY,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [15:0] PRE_LAST = 16'(PRE_LEN - 1);
  localparam logic [15:0] PAY_LAST = 16'(PAY_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_LEN - 1);
  localparam logic [15:0] NFR      = 16'(NFRAMES);
  localparam logic        HAS_GAP  = (GAP_LEN != 0);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        stop_pend_q, stop_pend_d;

  logic        m_tvalid, m_tdata, m_tlast, s_tready;
  logic [4:0]  pre_idx;
  logic [15:0] frame_cnt_inc;
  logic        end_run;

  // Preamble goes out MSB first, so the bit index counts down from PRE_LEN-1.
  assign pre_idx       = 5'(PRE_LEN - 1) - cnt_q[4:0];
  assign frame_cnt_inc = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
  assign end_run       = stop_pend_q || stop || ((NFRAMES != 0) && (frame_cnt_inc == NFR));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    stop_pend_d = stop_pend_q;
    m_tvalid    = 1'b0;
    m_tdata     = 1'b0;
    m_tlast     = 1'b0;
    s_tready    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_PRE;
          cnt_d       = '0;
          frame_cnt_d = '0;
          stop_pend_d = 1'b0;
        end
      end

      ST_PRE: begin
        m_tvalid = 1'b1;
        m_tdata  = PRE_PAT[pre_idx];
        if (stop) stop_pend_d = 1'b1;
        if (bus.m_tready) begin
          if (cnt_q == PRE_LAST) begin
            state_d = ST_PAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      ST_PAY: begin
        m_tvalid = bus.s_tvalid;
        m_tdata  = bus.s_tdata;
        s_tready = bus.m_tready;
        m_tlast  = bus.s_tvalid && (cnt_q == PAY_LAST);
        if (stop) stop_pend_d = 1'b1;
        if (bus.s_tvalid && bus.m_tready) begin
          if (cnt_q == PAY_LAST) begin
            frame_cnt_d = frame_cnt_inc;
            cnt_d       = '0;
            if (end_run)      state_d = ST_DONE;
            else if (HAS_GAP) state_d = ST_GAP;
            else              state_d = ST_PRE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      // Gap timing is free-running; the modulator cannot stretch it.
      ST_GAP: begin
        if (stop) stop_pend_d = 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = (stop_pend_q || stop) ? ST_DONE : ST_PRE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_DONE: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        stop_pend_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // All outputs decode from state, so asserting resetn zeroes them without waiting for a clock.
  assign bus.m_tvalid = m_tvalid;
  assign bus.m_tdata  = m_tdata;
  assign bus.m_tlast  = m_tlast;
  assign bus.s_tready = s_tready;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: instance A (NFRAMES=2, gap 8) and instance B (run-until-stop, no gap),
// expected beats queued per instance at start and popped on each output handshake.
module tb_frame_sequencer;

  typedef struct packed {
    logic d;
    logic l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn_a, resetn_b, start_a, start_b, stop_a, stop_b;
  logic src_en_a, src_en_b, rdy_a, rdy_b;
  logic busy_a, busy_b, done_a, done_b;
  logic [15:0] fcnt_a, fcnt_b;

  frame_sequencer_if ifa ();
  frame_sequencer_if ifb ();

  logic bits_a [512];
  logic bits_b [512];
  int   src_idx [2];
  int   hs [2];
  int   cyc [2];
  int   last_cyc [2];
  int   done_cnt [2];
  logic armed [2];
  logic held_v [2];
  logic held_d [2];
  exp_t qa [$];
  exp_t qb [$];
  int   gap_a [$];
  int   gap_b [$];

  int n_checks = 0;
  int n_errors = 0;

  assign ifa.s_tvalid = src_en_a;
  assign ifa.s_tdata  = bits_a[src_idx[0]];
  assign ifa.m_tready = rdy_a;
  assign ifb.s_tvalid = src_en_b;
  assign ifb.s_tdata  = bits_b[src_idx[1]];
  assign ifb.m_tready = rdy_b;

  frame_sequencer #(.NFRAMES(2)) dut_a (
    .clk(clk), .resetn(resetn_a), .start(start_a), .stop(stop_a), .bus(ifa),
    .busy(busy_a), .done(done_a), .frame_cnt(fcnt_a)
  );

  frame_sequencer #(.NFRAMES(0), .GAP_LEN(0)) dut_b (
    .clk(clk), .resetn(resetn_b), .start(start_b), .stop(stop_b), .bus(ifb),
    .busy(busy_b), .done(done_b), .frame_cnt(fcnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frames(input int k, input int nfr);
    logic [15:0] pat;
    exp_t e;
    int base;
    pat  = 16'hA5A5;
    base = src_idx[k];
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < 16; i++) begin
        e.d = pat[15-i];
        e.l = 1'b0;
        if (k == 0) qa.push_back(e); else qb.push_back(e);
      end
      for (int i = 0; i < 64; i++) begin
        e.d = (k == 0) ? bits_a[base + f*64 + i] : bits_b[base + f*64 + i];
        e.l = (i == 63);
        if (k == 0) qa.push_back(e); else qb.push_back(e);
      end
    end
  endtask

  // Output monitor: hold rule, scoreboard pop, gap timing, source advance, done count.
  task automatic mon(input int k, input logic v, input logic d, input logic l, input logic r,
                     input logic srdy, input logic svld, input logic dn, input logic rn);
    exp_t e;
    int   qsz;
    cyc[k]++;
    if (!rn) begin
      held_v[k] = 1'b0;
      armed[k]  = 1'b0;
      return;
    end
    if (held_v[k]) begin
      chk("stall_hold_vld", v, 1);
      chk("stall_hold_dat", d, held_d[k]);
    end
    held_v[k] = v && !r;
    held_d[k] = d;
    if (v && armed[k]) begin
      if (k == 0) gap_a.push_back(cyc[k] - last_cyc[k]); else gap_b.push_back(cyc[k] - last_cyc[k]);
      armed[k] = 1'b0;
    end
    if (v && r) begin
      hs[k]++;
      qsz = (k == 0) ? qa.size() : qb.size();
      chk("sb_beat_expected", (qsz != 0), 1);
      if (qsz != 0) begin
        e = (k == 0) ? qa.pop_front() : qb.pop_front();
        chk("sb_tdata", d, e.d);
        chk("sb_tlast", l, e.l);
      end
      if (l) begin
        armed[k]    = 1'b1;
        last_cyc[k] = cyc[k];
      end
    end
    if (srdy && svld) src_idx[k]++;
    if (dn) begin
      done_cnt[k]++;
      armed[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, ifa.m_tvalid, ifa.m_tdata, ifa.m_tlast, rdy_a, ifa.s_tready, src_en_a, done_a, resetn_a);
    mon(1, ifb.m_tvalid, ifb.m_tdata, ifb.m_tlast, rdy_b, ifb.s_tready, src_en_b, done_b, resetn_b);
  end

  initial begin
    logic [3:0] rpat;
    int base, d0;
    rpat = 4'b1001;
    for (int i = 0; i < 512; i++) begin
      bits_a[i] = 1'($urandom_range(0, 1));
      bits_b[i] = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < 2; k++) begin
      src_idx[k] = 0; hs[k] = 0; cyc[k] = 0; last_cyc[k] = 0; done_cnt[k] = 0;
      armed[k] = 1'b0; held_v[k] = 1'b0; held_d[k] = 1'b0;
    end
    resetn_a = 1'b0; resetn_b = 1'b0;
    start_a = 1'b0; start_b = 1'b0; stop_a = 1'b0; stop_b = 1'b0;
    src_en_a = 1'b1; src_en_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_mvld_a", ifa.m_tvalid, 0);
    chk("rst_srdy_a", ifa.s_tready, 0);
    chk("rst_mlast_a", ifa.m_tlast, 0);
    chk("rst_fcnt_a", fcnt_a, 0);
    chk("rst_mvld_b", ifb.m_tvalid, 0);
    chk("rst_busy_b", busy_b, 0);
    tick();
    resetn_a = 1'b1; resetn_b = 1'b1;
    repeat (2) tick();

    // Stop in IDLE must not start anything
    stop_a = 1'b1; tick(); stop_a = 1'b0;
    repeat (2) tick();
    chk("idle_stop_busy", busy_a, 0);

    // A run 1: two frames, preamble stalls, start while busy, s_tvalid bubble in frame 2
    base = src_idx[0];
    d0   = done_cnt[0];
    push_frames(0, 2);
    start_a = 1'b1; tick(); start_a = 1'b0;
    @(negedge clk);
    chk("first_pre_latency_vld", ifa.m_tvalid, 1);
    chk("first_pre_bit", ifa.m_tdata, 1);
    chk("busy_after_start", busy_a, 1);
    @(posedge clk); #1;
    for (int c = 0; hs[0] < 16 && c < 200; c++) begin
      rdy_a = rpat[3 - (c % 4)];
      tick();
    end
    rdy_a = 1'b1;
    chk("pre_handshakes_done", (hs[0] >= 16), 1);
    repeat (5) tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int c = 0; c < 2000 && src_idx[0] != base + 84; c++) tick();
    chk("reach_f2_bit20", src_idx[0], base + 84);
    src_en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bubble_mvld_low", ifa.m_tvalid, 0);
      @(posedge clk); #1;
    end
    src_en_a = 1'b1;
    for (int c = 0; c < 2000 && done_cnt[0] == d0; c++) tick();
    chk("a1_done_seen", done_cnt[0], d0 + 1);
    repeat (3) tick();
    chk("a1_done_once", done_cnt[0], d0 + 1);
    chk("a1_frame_cnt", fcnt_a, 2);
    chk("a1_idle", busy_a, 0);
    chk("a1_sb_drained", qa.size(), 0);
    chk("a1_gap_count", gap_a.size(), 1);
    if (gap_a.size() != 0) chk("a1_gap_len", gap_a.pop_front(), 9);

    // A run 2: stop during GAP ends the run after frame 1
    d0 = done_cnt[0];
    push_frames(0, 1);
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int c = 0; c < 2000 && !armed[0]; c++) tick();
    chk("a2_reach_gap", armed[0], 1);
    chk("a2_busy_in_gap", busy_a, 1);
    stop_a = 1'b1; tick(); stop_a = 1'b0;
    for (int c = 0; c < 200 && done_cnt[0] == d0; c++) tick();
    chk("a2_done_seen", done_cnt[0], d0 + 1);
    repeat (3) tick();
    chk("a2_frame_cnt", fcnt_a, 1);
    chk("a2_sb_drained", qa.size(), 0);
    chk("a2_no_gap", gap_a.size(), 0);

    // B run 1: run-until-stop, stop at payload bit 10 of frame 3, no gap between frames
    base = src_idx[1];
    d0   = done_cnt[1];
    push_frames(1, 3);
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int c = 0; c < 3000 && src_idx[1] != base + 138; c++) tick();
    chk("b1_reach_f3_bit10", src_idx[1], base + 138);
    stop_b = 1'b1; tick(); stop_b = 1'b0;
    for (int c = 0; c < 2000 && done_cnt[1] == d0; c++) tick();
    chk("b1_done_seen", done_cnt[1], d0 + 1);
    repeat (3) tick();
    chk("b1_done_once", done_cnt[1], d0 + 1);
    chk("b1_frame_cnt", fcnt_b, 3);
    chk("b1_sb_drained", qb.size(), 0);
    chk("b1_gap_count", gap_b.size(), 2);
    while (gap_b.size() != 0) chk("b1_gap0_next_cycle", gap_b.pop_front(), 1);

    // B run 2: asynchronous reset at payload bit 30 of frame 2
    base = src_idx[1];
    push_frames(1, 2);
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int c = 0; c < 3000 && src_idx[1] != base + 94; c++) tick();
    chk("b2_reach_f2_bit30", src_idx[1], base + 94);
    chk("b2_fcnt_before_rst", fcnt_b, 1);
    #2 resetn_b = 1'b0;
    #1;
    chk("arst_mvld", ifb.m_tvalid, 0);
    chk("arst_srdy", ifb.s_tready, 0);
    chk("arst_mdata", ifb.m_tdata, 0);
    chk("arst_busy", busy_b, 0);
    chk("arst_fcnt", fcnt_b, 0);
    qb.delete();
    gap_b.delete();
    @(posedge clk); #1;
    resetn_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_mvld", ifb.m_tvalid, 0);
    end
    chk("post_rst_fcnt", fcnt_b, 0);
    chk("post_rst_busy", busy_b, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter PRE_LEN, default 16: number of preamble bits per frame, 1..32.
REQ-002 Parameter PRE_PAT, default 32'h0000_A5A5: preamble pattern; the low PRE_LEN bits are used, sent MSB first.
REQ-003 Parameter PAY_LEN, default 64: payload bits per frame, 1..65535.
REQ-004 Parameter GAP_LEN, default 8: idle cycles between frames, 0..65535.
REQ-005 Parameter NFRAMES, default 0: frames per run; 0 means run until stop.
REQ-006 clk  in  1: single clock; all state updates on the rising edge.
REQ-007 resetn  in  1: asynchronous, active-low reset.
REQ-008 start  in  1: single-cycle pulse that starts a run.
REQ-009 stop  in  1: single-cycle pulse requesting the run end after the current frame.
REQ-010 s_tvalid  in  1: upstream bit-source valid.
REQ-011 s_tdata  in  1: upstream payload bit.
REQ-012 s_tready  out  1: ready to upstream source.
REQ-013 m_tvalid  out  1: valid to modulator.
REQ-014 m_tdata  out  1: bit to modulator.
REQ-015 m_tready  in  1: modulator ready.
REQ-016 m_tlast  out  1: marks the last payload bit of a frame.
REQ-017 busy  out  1: high in every state except IDLE.
REQ-018 done  out  1: one-cycle pulse at the end of a run.
REQ-019 frame_cnt  out  16: number of completed frames in the current run.

Function
REQ-020 States SHALL be IDLE, PRE, PAY, GAP and DONE, with one bit counter (16 bits) shared across states and a stop_pend flag.
REQ-021 IDLE: start=1 -> PRE with bit counter=0, frame_cnt=0, stop_pend=0; stop is ignored in IDLE.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 PRE: m_tvalid=1, m_tdata=PRE_PAT[PRE_LEN-1-cnt], s_tready=0; the counter advances only on m_tvalid&&m_tready.
REQ-024 PRE -> PAY on the handshake of bit PRE_LEN-1; the counter resets to 0.
REQ-025 PAY is a combinational pass-through: m_tvalid=s_tvalid, m_tdata=s_tdata, s_tready=m_tready; the counter advances on s_tvalid&&m_tready.
REQ-026 m_tlast=1 in PAY when cnt==PAY_LEN-1, qualified by m_tvalid; 0 otherwise.
REQ-027 On the handshake of the last payload bit, frame_cnt SHALL increment, saturating at 16'hFFFF.
REQ-028 After the last payload bit: go to DONE if stop_pend=1, a stop arrives in the same cycle, or NFRAMES!=0 and the incremented frame_cnt==NFRAMES.
REQ-029 Otherwise after the last payload bit: go to GAP if GAP_LEN>0, else directly to PRE.
REQ-030 GAP: m_tvalid=0, s_tready=0; the counter increments every cycle regardless of m_tready; exit to PRE after GAP_LEN cycles.
REQ-031 A stop pulse in PRE, PAY or GAP SHALL set stop_pend.
REQ-032 A stop seen in GAP SHALL make GAP exit to DONE instead of PRE.
REQ-033 DONE lasts exactly one cycle: done=1, m_tvalid=0, s_tready=0, then IDLE.
REQ-034 In IDLE and DONE, m_tvalid=0, s_tready=0, m_tdata=0 and m_tlast=0.
REQ-035 m_tdata and m_tvalid SHALL be held stable while m_tvalid=1 and m_tready=0 in PRE.
REQ-036 Latency: the first preamble bit is valid the cycle after start is sampled.
REQ-037 No payload bit SHALL be dropped or duplicated; a payload handshake occurs only when s_tvalid, s_tready and m_tready are all high.

Reset
REQ-038 resetn=0 SHALL immediately force state=IDLE, counters=0, stop_pend=0, frame_cnt=0, and all outputs 0, including mid-frame.
REQ-039 After resetn is released, the block stays in IDLE until the next start pulse; a partial frame is never resumed.

Verification
REQ-040 Defaults, NFRAMES=2, m_tready=1, s_tvalid=1, start pulse -> 16 bits 1010010110100101, then 64 payload bits with m_tlast on the 64th, then 8 idle cycles, then frame 2; done pulses once and frame_cnt=2.
REQ-041 m_tready toggles 1,0,0,1 during PRE -> each preamble bit is held during stalls and no bit is skipped; the preamble still totals 16 handshakes.
REQ-042 NFRAMES=0 with a stop pulse at payload bit 10 of frame 3 -> frame 3 completes with no GAP, then DONE, and frame_cnt=3.
REQ-043 GAP_LEN=0 -> the first preamble bit of frame n+1 is valid the cycle after m_tlast of frame n.
REQ-044 s_tvalid is low for 5 cycles mid-payload -> m_tvalid=0 for those cycles, the counter holds, and m_tlast still falls on payload bit 64.
REQ-045 resetn is asserted at payload bit 30 -> outputs go to 0 asynchronously; after release with no start, m_tvalid stays 0 for 20 cycles and frame_cnt=0.
